chacha_stream_feeder: RTL and testbench
=======================================

# chacha_stream_feeder

Upstream sequencer for `chacha20_poly1305_core`. It packs a 32-bit word stream into 512-bit blocks and drives the core's `init`/`next`/`done` handshake once per message and once per block. It unpacks each 512-bit result back into a 32-bit output stream and returns the 128-bit tag at end of message. Input filling overlaps core processing and output draining.

## Interface
- `TIMEOUT_CYCLES`, 50000: maximum cycles spent in any core-wait state before abort.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `s_valid` in 1, `s_ready` out 1, `s_data` in 32, `s_last` in 1: input word stream; `s_last` marks the final word of a message.
- `s_encdec` in 1: sampled on the first accepted word of a message.
- `m_valid` out 1, `m_ready` in 1, `m_data` out 32, `m_last` out 1: output word stream.
- `core_init`, `core_next`, `core_done` out 1: one-cycle pulses to the core.
- `core_encdec` out 1: latched `s_encdec`.
- `core_data_in` out 512: block presented to the core.
- `core_ready`, `core_valid`, `core_tag_ok` in 1: core status.
- `core_data_out` in 512: core result block.
- `core_tag` in 128: core tag.
- `tag_valid` out 1: one-cycle pulse when `tag` is updated.
- `tag` out 128: holds the last captured tag.
- `err_timeout` out 1: sticky abort flag.

## Operation
- **Fill (in_buf, 16×32).**
  - Word k is written to bits [511-32k -: 32].
  - `s_ready` = in_buf not full and no abort pending.
  - `s_last` or the 16th word closes the block. Unused words are zero; word count n (1..16) and a last flag are stored with the block.
- **Handoff.** When the control FSM is in IDLE or NEXT_BLK and in_buf holds a closed block:
  - copy in_buf to `core_data_in`; it stays stable until the result is captured;
  - free in_buf the same cycle.
- **Control FSM states:** IDLE, INIT, WAIT_RDY, NEXT, WAIT_VALID, CAPTURE, NEXT_BLK, DONE, WAIT_TAG.
  - IDLE→INIT on the first block of a message. INIT→WAIT_RDY.
  - WAIT_RDY→NEXT when `core_ready`=1.
  - NEXT→WAIT_VALID after one cycle.
  - WAIT_VALID→CAPTURE when `core_valid`=1. `core_valid` is ignored in the cycle `core_next` is high.
  - CAPTURE waits for out_buf empty, then loads out_buf with `core_data_out` and n.
    - Not the last block: →NEXT_BLK.
    - Last block: →DONE.
  - NEXT_BLK→NEXT once a new block is handed off. Later blocks of a message skip INIT.
  - DONE→WAIT_TAG.
  - WAIT_TAG→IDLE when `core_tag_ok`=1. On that transition `tag`←`core_tag` and `tag_valid` pulses.
- **Drain (out_buf).**
  - Emits words 0..n-1 MSB-first.
  - `m_last` is high on word n-1 of a last block.
  - out_buf is freed on the final handshake.
- **Timeout.**
  - The counter resets on each state entry and counts in WAIT_RDY, WAIT_VALID and WAIT_TAG.
  - Reaching `TIMEOUT_CYCLES`: `err_timeout`←1; in_buf, out_buf and FSM are cleared to IDLE.
  - `err_timeout` is cleared only by `rst`.
- **Boundary cases.**
  - `s_last` on the 16th word: full block, n=16.
  - Message of 1 word: n=1, a single `core_next`.
  - A new message may start filling during WAIT_TAG of the previous one. It is handed off only after IDLE.

## Timing
- **Reset values:** all outputs 0, including `core_data_in`, `tag` and `err_timeout`; FSM in IDLE; buffers empty.
- **Pulse spacing:** `core_init` and `core_next` are never high in the same cycle, and are separated by at least one cycle.
- **Handshake order:** `core_done` is issued ≥1 cycle after the last capture.
- **Latency, last input word to `core_init`:** 2 cycles (close, handoff+INIT).
- **Latency, `core_valid` to first `m_valid`:** 1 cycle when out_buf is empty.
- **Backpressure:** `m_valid` stays asserted with `m_data` stable until `m_ready`.
- **Throughput:** one word per cycle on each stream.

## Configuration
- **`CHACHA_FEEDER_STATS_EN` defined:**
  - adds outputs `blk_count` (32, blocks captured) and `stall_count` (32, cycles with CAPTURE blocked by a full out_buf);
  - both reset to 0 and wrap.
- **Not defined:** the ports and counters are absent.

## Structure
- **Package `chacha_feeder_pkg`:** FSM state enum, `BLK_WORDS`=16, `WORD_W`=32, `BLK_W`=512, block-meta struct {n[4:0], last}.
- **Sub-module `chacha_word_buf`:** a 16-word buffer with fill/drain index, count and last flag. It is instantiated twice: pack mode for in_buf, unpack mode for out_buf.

## Test plan
The bench uses a stub core: `core_data_out` = `core_data_in` ^ {16{32'hFFFFFFFF}}; `core_valid` 10 cycles after `core_next`; `core_tag_ok` 5 cycles after `core_done`; `core_tag` = 128'h1.
- **Full block.** 16 words alternating 32'hcafebabe/32'hdeadbeef with `s_last` on word 15 →
  - `core_data_in`={8{64'hcafebabedeadbeef}}; one `core_init` then one `core_next`;
  - outputs 32'h35014541/32'h21524110 alternating; `m_last` on word 15;
  - `tag`=128'h1 with one `tag_valid` pulse.
- **Two blocks.** 32 words of 32'h01234567, `s_last` on word 31 → one `core_init`, two `core_next`, one `core_done`; 32 output words of 32'hFEDCBA98.
- **Partial block.** 3 words with `s_last` → `core_data_in`[415:0]=0; exactly 3 output words, `m_last` on the third.
- **Backpressure.** `m_ready` low for 40 cycles → `s_ready` drops after in_buf fills; no word lost or duplicated; output matches input^FFFFFFFF.
- **Timeout.** Stub never asserts `core_valid`, `TIMEOUT_CYCLES`=100 → `err_timeout`=1 within 100 cycles; FSM returns to IDLE.
- **Reset mid-block.** Assert `rst` after 8 words → all outputs 0; the next message processes correctly.

Source files
------------

// File: rtl/chacha_feeder_pkg.sv
// Shared sizes, FSM state encoding and block metadata for the ChaCha stream feeder.
package chacha_feeder_pkg;
   localparam int BLK_WORDS = 16;
   localparam int WORD_W    = 32;
   localparam int BLK_W     = BLK_WORDS * WORD_W;
   localparam int TAG_W     = 128;

   typedef enum logic [3:0] {
      IDLE, INIT, WAIT_RDY, NEXT, WAIT_VALID, CAPTURE, NEXT_BLK, DONE, WAIT_TAG
   } feeder_state_e;

   typedef struct packed {
      logic [4:0] n;
      logic       last;
   } blk_meta_t;
endpackage

// File: rtl/chacha_word_buf.sv
// 16-word block buffer. Pack mode fills MSB-first word by word; unpack mode
// loads a whole block and drains it from the top, meta.n counting words left.
module chacha_word_buf
   import chacha_feeder_pkg::*;
#(
   parameter bit UNPACK = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              push,
   input  logic [WORD_W-1:0] push_data,
   input  logic              push_last,
   input  logic              load,
   input  logic [BLK_W-1:0]  load_data,
   input  blk_meta_t         load_meta,
   input  logic              pop,
   output logic              full,
   output logic [BLK_W-1:0]  blk,
   output blk_meta_t         meta
);
   generate
      if (UNPACK) begin : g_unpack
         logic unused_pack;
         assign unused_pack = ^{push, push_data, push_last};

         always_ff @(posedge clk) begin
            if (rst || clr || (pop && full && meta.n == 5'd1)) begin
               full <= 1'b0;
               blk  <= '0;
               meta <= '0;
            end else if (load && !full) begin
               full <= 1'b1;
               blk  <= load_data;
               meta <= load_meta;
            end else if (pop && full) begin
               blk    <= blk << WORD_W;
               meta.n <= meta.n - 5'd1;
            end
         end
      end else begin : g_pack
         logic unused_unpack;
         assign unused_unpack = ^{load, load_data, load_meta};

         // Clearing on pop keeps the words past a short block at zero.
         always_ff @(posedge clk) begin
            if (rst || clr || (pop && full)) begin
               full <= 1'b0;
               blk  <= '0;
               meta <= '0;
            end else if (push && !full) begin
               blk[BLK_W-1-WORD_W*int'(meta.n[3:0]) -: WORD_W] <= push_data;
               meta.n    <= meta.n + 5'd1;
               meta.last <= push_last;
               full      <= push_last || meta.n == 5'(BLK_WORDS - 1);
            end
         end
      end
   endgenerate
endmodule

// File: rtl/chacha_stream_feeder.sv
// Word-stream front end for chacha20_poly1305_core: packs blocks, sequences
// init/next/done, unpacks results. CHACHA_FEEDER_STATS_EN adds block/stall counters.
module chacha_stream_feeder
   import chacha_feeder_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [WORD_W-1:0] s_data,
   input  logic              s_last,
   input  logic              s_encdec,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [WORD_W-1:0] m_data,
   output logic              m_last,
   output logic              core_init,
   output logic              core_next,
   output logic              core_done,
   output logic              core_encdec,
   output logic [BLK_W-1:0]  core_data_in,
   input  logic              core_ready,
   input  logic              core_valid,
   input  logic              core_tag_ok,
   input  logic [BLK_W-1:0]  core_data_out,
   input  logic [TAG_W-1:0]  core_tag,
   output logic              tag_valid,
   output logic [TAG_W-1:0]  tag,
   output logic              err_timeout
`ifdef CHACHA_FEEDER_STATS_EN
   ,
   output logic [31:0]       blk_count,
   output logic [31:0]       stall_count
`endif
);
   feeder_state_e    state;
   blk_meta_t        ib_meta, ob_meta, cur_meta;
   logic [BLK_W-1:0] ib_blk, ob_blk;
   logic             ib_full, ob_full, push, handoff, ob_load, ob_pop, abort, waiting;
   logic             cap_done, msg_start, enc_pend;
   logic [31:0]      tmo_cnt;
   logic             unused_ob;

   assign waiting = state inside {WAIT_RDY, WAIT_VALID, WAIT_TAG};
   assign abort   = waiting && tmo_cnt == 32'(TIMEOUT_CYCLES - 1);
   assign s_ready = !rst && !ib_full && !abort;
   assign push    = s_valid && s_ready;
   assign handoff = (state == IDLE || state == NEXT_BLK) && ib_full;
   // Capture straight out of WAIT_VALID when out_buf is free; CAPTURE only retries.
   assign ob_load = !ob_full && !abort &&
                    ((state == WAIT_VALID && core_valid) || (state == CAPTURE && !cap_done));

   assign m_valid   = ob_full;
   assign m_data    = ob_blk[BLK_W-1 -: WORD_W];
   assign m_last    = ob_full && ob_meta.last && ob_meta.n == 5'd1;
   assign ob_pop    = ob_full && m_ready;
   assign unused_ob = ^ob_blk[BLK_W-WORD_W-1:0];

   chacha_word_buf #(.UNPACK(1'b0)) u_in_buf (
      .clk(clk), .rst(rst), .clr(abort),
      .push(push), .push_data(s_data), .push_last(s_last),
      .load(1'b0), .load_data('0), .load_meta('0),
      .pop(handoff), .full(ib_full), .blk(ib_blk), .meta(ib_meta)
   );

   chacha_word_buf #(.UNPACK(1'b1)) u_out_buf (
      .clk(clk), .rst(rst), .clr(abort),
      .push(1'b0), .push_data('0), .push_last(1'b0),
      .load(ob_load), .load_data(core_data_out), .load_meta(cur_meta),
      .pop(ob_pop), .full(ob_full), .blk(ob_blk), .meta(ob_meta)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         core_init    <= 1'b0;
         core_next    <= 1'b0;
         core_done    <= 1'b0;
         core_encdec  <= 1'b0;
         core_data_in <= '0;
         cur_meta     <= '0;
         tag          <= '0;
         tag_valid    <= 1'b0;
         err_timeout  <= 1'b0;
         tmo_cnt      <= '0;
         cap_done     <= 1'b0;
         msg_start    <= 1'b1;
         enc_pend     <= 1'b0;
      end else begin
         core_init <= 1'b0;
         core_next <= 1'b0;
         core_done <= 1'b0;
         tag_valid <= 1'b0;
         // Wait states are always entered from a one-cycle state, so this restarts per entry.
         tmo_cnt   <= waiting ? tmo_cnt + 32'd1 : '0;
         if (push && msg_start) enc_pend <= s_encdec;
         if (push) msg_start <= s_last;
         if (handoff) begin
            core_data_in <= ib_blk;
            cur_meta     <= ib_meta;
         end
         if (abort) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
            cap_done    <= 1'b0;
            msg_start   <= 1'b1;
         end else begin
            case (state)
               IDLE: if (handoff) begin
                  state       <= INIT;
                  core_init   <= 1'b1;
                  core_encdec <= enc_pend;
               end
               INIT: state <= WAIT_RDY;
               WAIT_RDY: if (core_ready) begin
                  state     <= NEXT;
                  core_next <= 1'b1;
               end
               NEXT: state <= WAIT_VALID;
               WAIT_VALID: if (core_valid) begin
                  state    <= CAPTURE;
                  cap_done <= ob_load;
               end
               CAPTURE: if (cap_done || ob_load) begin
                  cap_done  <= 1'b0;
                  state     <= cur_meta.last ? DONE : NEXT_BLK;
                  core_done <= cur_meta.last;
               end
               NEXT_BLK: if (handoff) begin
                  state     <= NEXT;
                  core_next <= 1'b1;
               end
               DONE: state <= WAIT_TAG;
               WAIT_TAG: if (core_tag_ok) begin
                  state     <= IDLE;
                  tag       <= core_tag;
                  tag_valid <= 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef CHACHA_FEEDER_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         blk_count   <= '0;
         stall_count <= '0;
      end else begin
         if (ob_load) blk_count <= blk_count + 32'd1;
         if (state == CAPTURE && !cap_done && ob_full) stall_count <= stall_count + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_chacha_stream_feeder.sv
// Bench for chacha_stream_feeder: stub core, per-message reference model built
// from the input words (pack, invert, unpack), directed message sequence.
module tb_chacha_stream_feeder;
   localparam int TMO = 100;

   logic clk = 1'b0;
   logic rst;
   logic s_valid, s_ready, s_last, s_encdec;
   logic [31:0] s_data;
   logic m_valid, m_ready, m_last;
   logic [31:0] m_data;
   logic core_init, core_next, core_done, core_encdec;
   logic [511:0] core_data_in, core_data_out;
   logic core_ready;
   logic core_valid = 1'b0;
   logic core_tag_ok = 1'b0;
   logic [127:0] core_tag, tag;
   logic tag_valid, err_timeout;

   always #5 clk = ~clk;

   chacha_stream_feeder #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .s_encdec(s_encdec),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .core_init(core_init), .core_next(core_next), .core_done(core_done),
      .core_encdec(core_encdec), .core_data_in(core_data_in),
      .core_ready(core_ready), .core_valid(core_valid), .core_tag_ok(core_tag_ok),
      .core_data_out(core_data_out), .core_tag(core_tag),
      .tag_valid(tag_valid), .tag(tag), .err_timeout(err_timeout)
   );

   // Stub core: inverts the block, valid 10 cycles after next, tag_ok 5 after done.
   logic stub_no_valid;
   int   vcnt, tcnt;
   assign core_data_out = core_data_in ^ {16{32'hFFFFFFFF}};
   assign core_tag      = 128'h1;
   assign core_ready    = 1'b1;

   always @(posedge clk) begin
      core_valid  <= 1'b0;
      core_tag_ok <= 1'b0;
      if (rst) begin
         vcnt <= 0;
         tcnt <= 0;
      end else begin
         if (core_next) vcnt <= 9;
         else if (vcnt > 0) begin
            vcnt <= vcnt - 1;
            if (vcnt == 1) core_valid <= !stub_no_valid;
         end
         if (core_done) tcnt <= 4;
         else if (tcnt > 0) begin
            tcnt <= tcnt - 1;
            if (tcnt == 1) core_tag_ok <= 1'b1;
         end
      end
   end

   // Monitor: records what the DUT emits; all judging happens in the main sequence.
   int cyc, init_cnt, next_cnt, done_cnt, tagv_cnt, clash_cnt, sstall_cnt, hold_err;
   int cyc_next, cyc_err;
   logic prev_init, prev_next, prev_mv, prev_mr, enc_seen;
   logic [31:0] prev_md;
   logic [511:0] blk_q[$];
   logic [32:0]  got_q[$];

   always begin
      @(negedge clk);
      #1;
      cyc++;
      if (!rst) begin
         if (core_init) begin init_cnt++; enc_seen = core_encdec; end
         if (core_next) begin next_cnt++; blk_q.push_back(core_data_in); cyc_next = cyc; end
         if (core_done) done_cnt++;
         if (tag_valid) tagv_cnt++;
         if ((core_init && (core_next || prev_next)) || (core_next && prev_init)) clash_cnt++;
         if (m_valid && m_ready) got_q.push_back({m_last, m_data});
         if (s_valid && !s_ready) sstall_cnt++;
         if (prev_mv && !prev_mr && (!m_valid || m_data != prev_md)) hold_err++;
         if (err_timeout && cyc_err == 0) cyc_err = cyc;
      end
      prev_init = core_init;
      prev_next = core_next;
      prev_mv   = m_valid;
      prev_mr   = m_ready;
      prev_md   = m_data;
   end

   int checks, failures;

   task automatic chk(input string name, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic put(input logic [31:0] d, input logic l, input logic e);
      int t = 0;
      s_valid = 1'b1; s_data = d; s_last = l; s_encdec = e;
      while (!s_ready && t < 2000) begin @(negedge clk); t++; end
      if (t >= 2000) chk("s_ready_wait", 1'b0, 1'b1);
      @(negedge clk);
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic check_reset(input string pfx);
      chk({pfx, "_s_ready"}, s_ready, 0);
      chk({pfx, "_m_valid"}, m_valid, 0);
      chk({pfx, "_m_data"}, m_data, 0);
      chk({pfx, "_m_last"}, m_last, 0);
      chk({pfx, "_core_init"}, core_init, 0);
      chk({pfx, "_core_next"}, core_next, 0);
      chk({pfx, "_core_done"}, core_done, 0);
      chk({pfx, "_core_encdec"}, core_encdec, 0);
      chk({pfx, "_core_data_in"}, core_data_in, 0);
      chk({pfx, "_tag_valid"}, tag_valid, 0);
      chk({pfx, "_tag"}, tag, 0);
      chk({pfx, "_err_timeout"}, err_timeout, 0);
   endtask

   // mode 0: cafebabe/deadbeef alternating, 1: 01234567, else random
   task automatic run_msg(input int n, input int mode, input int bp_cycles);
      logic [31:0] w[$];
      logic [511:0] eb;
      logic [32:0] ev;
      logic enc;
      int i0, n0, d0, t0, s0, h0, nb, wc;
      enc = 1'($urandom);
      for (int k = 0; k < n; k++)
         case (mode)
            0: w.push_back((k % 2 == 0) ? 32'hcafebabe : 32'hdeadbeef);
            1: w.push_back(32'h01234567);
            default: w.push_back($urandom);
         endcase
      i0 = init_cnt; n0 = next_cnt; d0 = done_cnt; t0 = tagv_cnt; s0 = sstall_cnt; h0 = hold_err;
      got_q.delete();
      blk_q.delete();
      fork
         for (int k = 0; k < n; k++) put(w[k], k == n - 1, enc);
         if (bp_cycles > 0) begin
            m_ready = 1'b0;
            repeat (bp_cycles) @(negedge clk);
            m_ready = 1'b1;
         end
      join
      wc = 0;
      while ((tagv_cnt == t0 || got_q.size() < n) && wc < 3000) begin @(negedge clk); wc++; end
      repeat (3) @(negedge clk);
      chk($sformatf("msg%0d_completes", n), wc < 3000, 1);
      nb = (n + 15) / 16;
      chk("init_count", init_cnt - i0, 1);
      chk("next_count", next_cnt - n0, nb);
      chk("done_count", done_cnt - d0, 1);
      chk("tag_valid_count", tagv_cnt - t0, 1);
      chk("tag_value", tag, 128'h1);
      chk("core_encdec", enc_seen, enc);
      chk("out_word_count", got_q.size(), n);
      chk("blk_count", blk_q.size(), nb);
      for (int k = 0; k < n && k < got_q.size(); k++) begin
         ev = {k == n - 1, w[k] ^ 32'hFFFFFFFF};
         chk($sformatf("out_word%0d", k), got_q[k], ev);
      end
      for (int b = 0; b < nb && b < blk_q.size(); b++) begin
         eb = '0;
         for (int k = 0; k < 16 && b * 16 + k < n; k++) eb[511 - 32 * k -: 32] = w[b * 16 + k];
         chk($sformatf("core_blk%0d", b), blk_q[b], eb);
      end
      chk("m_hold_under_backpressure", hold_err - h0, 0);
      if (bp_cycles > 0) chk("s_ready_dropped", (sstall_cnt - s0) > 0, 1);
   endtask

   logic [511:0] full_const;
   logic [32:0]  w0, w1;
   int n_base;

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_encdec = 1'b0;
      m_ready = 1'b1; stub_no_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_reset("reset");
      rst = 1'b0;
      @(negedge clk);

      // Full block, s_last on the 16th word
      run_msg(16, 0, 0);
      full_const = {8{64'hcafebabedeadbeef}};
      chk("full_blk_const", blk_q[0], full_const);
      w0 = {1'b0, 32'h35014541};
      w1 = {1'b0, 32'h21524110};
      chk("full_out0", got_q[0], w0);
      chk("full_out1", got_q[1], w1);

      run_msg(32, 1, 0);                 // two blocks, one init
      run_msg(3, 2, 0);                  // partial block
      chk("partial_zero_tail", blk_q[0][415:0], 0);
      run_msg(1, 2, 0);                  // single word
      run_msg(64, 2, 40);                // output backpressure

      // Timeout: the stub never answers
      stub_no_valid = 1'b1;
      cyc_err = 0;
      n_base = next_cnt;
      for (int k = 0; k < 5; k++) put($urandom, k == 4, 1'b0);
      for (int t = 0; t < 400 && !err_timeout; t++) @(negedge clk);
      @(negedge clk);
      chk("tmo_next_issued", next_cnt - n_base, 1);
      chk("tmo_flag", err_timeout, 1);
      chk("tmo_window", (cyc_err - cyc_next) >= TMO && (cyc_err - cyc_next) <= TMO + 2, 1);
      chk("tmo_s_ready", s_ready, 1);
      chk("tmo_m_valid", m_valid, 0);
      stub_no_valid = 1'b0;
      run_msg(20, 2, 0);
      chk("tmo_sticky", err_timeout, 1);

      // Reset in the middle of filling a block
      for (int k = 0; k < 8; k++) put($urandom, 1'b0, 1'b1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_reset("rst_mid");
      rst = 1'b0;
      @(negedge clk);
      run_msg(20, 2, 0);

      chk("pulse_spacing", clash_cnt, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog");
   end
endmodule
